// File: rtl/el2_exu_alu_noc_seq_pkg.sv
// Shared types and defaults for the ALU NoC operand sequencer.
// Holds the FSM state encoding and the default latency and timeout values.
package noc_types;

    localparam int ALU_LAT_DEF = 1;
    localparam int TIMEOUT_DEF = 255;
    localparam int CNT_W_DEF   = 16;
    localparam int SEQ_CNT_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HAVE0 = 3'd1,
        ST_HAVE1 = 3'd2,
        ST_ISSUE = 3'd3,
        ST_EXEC  = 3'd4,
        ST_SEND  = 3'd5
    } noc_state_t;

    // Operand slot 0 is free while nothing, or only operand 1, is held.
    function automatic logic ready0_of(input noc_state_t s);
        return (s == ST_IDLE) || (s == ST_HAVE1);
    endfunction

    function automatic logic ready1_of(input noc_state_t s);
        return (s == ST_IDLE) || (s == ST_HAVE0);
    endfunction

    function automatic logic busy_of(input noc_state_t s);
        return (s == ST_ISSUE) || (s == ST_EXEC);
    endfunction

endpackage

// File: rtl/el2_exu_alu_noc_seq.sv
// Pairs two operand packets from the NoC, issues them to the ALU, waits out
// the ALU latency and hands the result to the sender; every output is registered.
module el2_exu_alu_noc_seq
    import noc_types::*;
#(
    parameter int ALU_LAT = ALU_LAT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             rx_valid0,
    input  logic             rx_valid1,
    input  logic             tx_ack,
    output logic             rx_ready0,
    output logic             rx_ready1,
    output logic             alu_valid,
    output logic             alu_busy,
    output logic             tx_enable,
    output logic [CNT_W-1:0] done_cnt,
    output logic             err_timeout,
    output logic             err_overrun
);

    localparam logic [SEQ_CNT_W:0]   TIMEOUT_LIM = (SEQ_CNT_W+1)'(TIMEOUT);
    localparam logic [SEQ_CNT_W-1:0] LAT_LOAD    = SEQ_CNT_W'(ALU_LAT);

    noc_state_t           state_q;
    noc_state_t           state_d;
    logic [SEQ_CNT_W-1:0] cnt_q;
    logic [SEQ_CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0]     done_d;
    logic                 err_timeout_d;
    logic                 err_overrun_d;
    logic [SEQ_CNT_W:0]   wait_next;

    assign wait_next = {1'b0, cnt_q} + {{SEQ_CNT_W{1'b0}}, 1'b1};

    // One shared counter: it counts up while waiting for a partner packet and
    // down while the ALU result is in flight; a partner arriving on the
    // timeout cycle still wins.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        done_d        = done_cnt;
        err_timeout_d = err_timeout;
        err_overrun_d = err_overrun;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            if ((rx_valid0 && !rx_ready0) || (rx_valid1 && !rx_ready1)) begin
                err_overrun_d = 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (rx_valid0 && rx_valid1) begin
                        state_d = ST_ISSUE;
                    end else if (rx_valid0) begin
                        state_d = ST_HAVE0;
                    end else if (rx_valid1) begin
                        state_d = ST_HAVE1;
                    end
                end

                ST_HAVE0: begin
                    if (rx_valid1) begin
                        state_d = ST_ISSUE;
                        cnt_d   = '0;
                    end else if (wait_next >= TIMEOUT_LIM) begin
                        state_d       = ST_IDLE;
                        cnt_d         = '0;
                        err_timeout_d = 1'b1;
                    end else begin
                        cnt_d = wait_next[SEQ_CNT_W-1:0];
                    end
                end

                ST_HAVE1: begin
                    if (rx_valid0) begin
                        state_d = ST_ISSUE;
                        cnt_d   = '0;
                    end else if (wait_next >= TIMEOUT_LIM) begin
                        state_d       = ST_IDLE;
                        cnt_d         = '0;
                        err_timeout_d = 1'b1;
                    end else begin
                        cnt_d = wait_next[SEQ_CNT_W-1:0];
                    end
                end

                ST_ISSUE: begin
                    state_d = ST_EXEC;
                    cnt_d   = LAT_LOAD;
                end

                ST_EXEC: begin
                    if (cnt_q <= SEQ_CNT_W'(1)) begin
                        state_d = ST_SEND;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - SEQ_CNT_W'(1);
                    end
                end

                ST_SEND: begin
                    if (tx_ack) begin
                        state_d = ST_IDLE;
                        done_d  = done_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state
    // register instead of trailing it by a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            done_cnt    <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            rx_ready0   <= 1'b1;
            rx_ready1   <= 1'b1;
            alu_valid   <= 1'b0;
            alu_busy    <= 1'b0;
            tx_enable   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_cnt    <= done_d;
            err_timeout <= err_timeout_d;
            err_overrun <= err_overrun_d;
            rx_ready0   <= ready0_of(state_d);
            rx_ready1   <= ready1_of(state_d);
            alu_valid   <= (state_d == ST_ISSUE);
            alu_busy    <= busy_of(state_d);
            tx_enable   <= (state_d == ST_SEND);
        end
    end

endmodule

// File: tb/tb_el2_exu_alu_noc_seq.sv
// Directed bench for the ALU NoC sequencer: completed operations are queued
// with their expected done_cnt and checked at each sender handshake.
module tb_el2_exu_alu_noc_seq;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             rx_valid0;
    logic             rx_valid1;
    logic             tx_ack;
    logic             rx_ready0;
    logic             rx_ready1;
    logic             alu_valid;
    logic             alu_busy;
    logic             tx_enable;
    logic [CNT_W-1:0] done_cnt;
    logic             err_timeout;
    logic             err_overrun;

    int               total = 0;
    int               bad = 0;
    int               model_done = 0;
    int               alu_pulses = 0;
    bit               hs_seen = 1'b0;
    logic [CNT_W-1:0] exp_q[$];

    el2_exu_alu_noc_seq #(
        .ALU_LAT(1),
        .TIMEOUT(4),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .rx_valid0  (rx_valid0),
        .rx_valid1  (rx_valid1),
        .tx_ack     (tx_ack),
        .rx_ready0  (rx_ready0),
        .rx_ready1  (rx_ready1),
        .alu_valid  (alu_valid),
        .alu_busy   (alu_busy),
        .tx_enable  (tx_enable),
        .done_cnt   (done_cnt),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at a falling edge, let the rising edge take
    // them, and return at the next falling edge with inputs idle.
    task automatic applyStimulus(input logic v0, input logic v1, input logic ack, input logic fl);
        logic             hs;
        logic [CNT_W-1:0] e;
        hs        = tx_enable && ack && !fl;
        rx_valid0 = v0;
        rx_valid1 = v1;
        tx_ack    = ack;
        flush     = fl;
        @(negedge clk);
        rx_valid0 = 1'b0;
        rx_valid1 = 1'b0;
        tx_ack    = 1'b0;
        flush     = 1'b0;
        if (alu_valid) alu_pulses++;
        if (hs) begin
            hs_seen = 1'b1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("[TB] FAIL scoreboard_underflow observed=%0d expected=no_handshake", done_cnt);
            end else begin
                e = exp_q.pop_front();
                checkOutput("done_cnt", 32'(done_cnt), 32'(e));
                checkOutput("tx_enable_drop", 32'(tx_enable), 32'd0);
            end
        end
    endtask

    task automatic pushExpected();
        model_done = (model_done + 1) % (1 << CNT_W);
        exp_q.push_back(CNT_W'(model_done));
    endtask

    task automatic drainOp();
        int n;
        n       = 0;
        hs_seen = 1'b0;
        while (!hs_seen && n < 20) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        checkOutput("drain_handshake", 32'(hs_seen), 32'd1);
    endtask

    // Back-to-back pair with the sender acking immediately: pair, issue,
    // exec and send take ALU_LAT+3 edges.
    task automatic runOp();
        int n;
        pushExpected();
        hs_seen = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        n = 1;
        while (!hs_seen && n < 20) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        checkOutput("op_latency", 32'(n), 32'd4);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        rx_valid0 = 1'b0;
        rx_valid1 = 1'b0;
        tx_ack    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_ready0", 32'(rx_ready0), 32'd1);
        checkOutput("rst_ready1", 32'(rx_ready1), 32'd1);
        checkOutput("rst_alu_valid", 32'(alu_valid), 32'd0);
        checkOutput("rst_busy", 32'(alu_busy), 32'd0);
        checkOutput("rst_tx_enable", 32'(tx_enable), 32'd0);
        checkOutput("rst_done", 32'(done_cnt), 32'd0);
        checkOutput("rst_errs", 32'({err_timeout, err_overrun}), 32'd0);
        rst = 1'b0;

        // Operand 0 at t0, operand 1 at t3, ack held high.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("have0_ready0", 32'(rx_ready0), 32'd0);
        checkOutput("have0_ready1", 32'(rx_ready1), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        pushExpected();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("t4_alu_valid", 32'(alu_valid), 32'd1);
        checkOutput("t4_busy", 32'(alu_busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_alu_valid", 32'(alu_valid), 32'd0);
        checkOutput("t5_tx_enable", 32'(tx_enable), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t6_tx_enable", 32'(tx_enable), 32'd1);
        checkOutput("t6_busy", 32'(alu_busy), 32'd0);
        hs_seen = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t7_handshake", 32'(hs_seen), 32'd1);

        // Partner arrives on the very cycle the wait counter hits TIMEOUT.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("have1_ready0", 32'(rx_ready0), 32'd1);
        checkOutput("have1_ready1", 32'(rx_ready1), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        pushExpected();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("late_partner_issue", 32'(alu_valid), 32'd1);
        checkOutput("late_partner_no_err", 32'(err_timeout), 32'd0);
        drainOp();

        // Lone operand 0 times out after four waiting cycles.
        alu_pulses = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_timeout_waiting", 32'({rx_ready0, err_timeout}), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("timeout_flag", 32'(err_timeout), 32'd1);
        checkOutput("timeout_idle", 32'({rx_ready0, rx_ready1}), 32'd3);
        checkOutput("timeout_no_issue", 32'(alu_pulses), 32'd0);

        // Second operand 0 arriving during EXEC is an overrun and is ignored.
        checkOutput("no_overrun_yet", 32'(err_overrun), 32'd0);
        alu_pulses = 0;
        pushExpected();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("overrun_flag", 32'(err_overrun), 32'd1);
        checkOutput("overrun_send", 32'(tx_enable), 32'd1);
        drainOp();
        checkOutput("overrun_single_issue", 32'(alu_pulses), 32'd1);

        // Flush in SEND without ack, then flush coinciding with ack.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_flush_send", 32'(tx_enable), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("flush_tx_enable", 32'(tx_enable), 32'd0);
        checkOutput("flush_ready", 32'({rx_ready0, rx_ready1}), 32'd3);
        checkOutput("flush_done_kept", 32'(done_cnt), 32'(model_done));
        checkOutput("flush_errs_kept", 32'({err_timeout, err_overrun}), 32'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("flush_ack_no_count", 32'(done_cnt), 32'(model_done));
        checkOutput("flush_ack_tx_enable", 32'(tx_enable), 32'd0);

        // Asynchronous reset in EXEC, then normal pairing again.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("exec_busy", 32'(alu_busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_busy", 32'(alu_busy), 32'd0);
        checkOutput("async_ready", 32'({rx_ready0, rx_ready1}), 32'd3);
        checkOutput("async_done", 32'(done_cnt), 32'd0);
        checkOutput("async_errs", 32'({err_timeout, err_overrun}), 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        model_done = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_quiet", 32'({alu_valid, tx_enable}), 32'd0);
        runOp();

        // Run the counter to its maximum and wrap it on the next ack.
        for (int i = 0; i < (1 << CNT_W) - 1; i++) runOp();
        checkOutput("wrap_zero", 32'(done_cnt), 32'd0);
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
